// File: rtl/gsm_src_pkg.sv
// Shared constants and the Gray-to-4-ASK level map for the GSM test-signal source.
package gsm_src_pkg;

    localparam int LFSR_W          = 22;
    localparam int TAP_HI          = 21;
    localparam int TAP_LO          = 20;

    localparam int UPSAMPLE        = 4;
    localparam int SAMPLES_PER_SYM = 4;
    localparam int PH_W            = $clog2(UPSAMPLE);
    localparam int SC_W            = $clog2(SAMPLES_PER_SYM);

    localparam logic [PH_W-1:0] PH_LOAD = PH_W'(1);
    localparam logic [PH_W-1:0] PH_PRE  = PH_W'(UPSAMPLE - 2);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(UPSAMPLE - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLES_PER_SYM - 1);

    // Levels for the default inner magnitude a = 0.25 in 1s17.
    localparam int MAG_DEF = 32768;
    localparam int LVL_N3  = -3 * MAG_DEF;
    localparam int LVL_N1  = -MAG_DEF;
    localparam int LVL_P1  = MAG_DEF;
    localparam int LVL_P3  = 3 * MAG_DEF;

    function automatic int gray_map(input logic [1:0] bits, input int mag);
        case (bits)
            2'b00:   return -3 * mag;
            2'b01:   return -mag;
            2'b11:   return mag;
            default: return 3 * mag;
        endcase
    endfunction

endpackage

// File: rtl/gsm_lfsr22.sv
// Seedable PRBS-22 (x^22+x^21+1) that advances two steps per enable and exposes its top two bits.
module gsm_lfsr22
    import gsm_src_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 22'h3FFFFF
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       adv,
    output logic [1:0] taps
);

    // An all-zero seed would lock the register, so it is replaced by 1.
    localparam logic [LFSR_W-1:0] SEED_EFF = (SEED == '0) ? LFSR_W'(1) : SEED;

    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] step1;
    logic [LFSR_W-1:0] step2;

    always_comb begin
        step1 = {lfsr[LFSR_W-2:0], lfsr[TAP_HI] ^ lfsr[TAP_LO]};
        step2 = {step1[LFSR_W-2:0], step1[TAP_HI] ^ step1[TAP_LO]};
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= SEED_EFF;
        end else if (adv) begin
            lfsr <= step2;
        end
    end

    assign taps = {lfsr[TAP_HI], lfsr[TAP_LO]};

endmodule

// File: rtl/gsm_sym_source.sv
// Sample/symbol timing master and PRBS 4-ASK source feeding the GSM pulse-shaping filter.
// Define GSM_SRC_ZOH_EN for zero-order hold instead of zero stuffing between symbols.
module gsm_sym_source
    import gsm_src_pkg::*;
#(
    parameter int                       WIDTH = 18,
    parameter logic signed [WIDTH-1:0]  MAG   = 18'sd32768,
    parameter logic [LFSR_W-1:0]        SEED  = 22'h3FFFFF
) (
    input  logic                    sys_clk,
    input  logic                    reset_n,
    input  logic                    run,
    output logic                    sam_clk_en,
    output logic                    sym_clk_en,
    output logic signed [WIDTH-1:0] x_out,
    output logic [1:0]              sym_out
);

    logic [PH_W-1:0]         ph;
    logic [SC_W-1:0]         sc;
    logic [1:0]              bits;
    logic                    load_edge;
    logic                    sym_load;
    logic                    adv;
    logic signed [WIDTH-1:0] lvl;

    assign load_edge = (ph == PH_LOAD);
    assign sym_load  = load_edge && (sc == '0);
    assign adv       = sym_load && run;
    assign lvl       = WIDTH'(gray_map(bits, int'(MAG)));

    // Bits are read before the advance, so x_out lags the LFSR state by one edge.
    gsm_lfsr22 #(
        .SEED (SEED)
    ) u_lfsr (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .adv     (adv),
        .taps    (bits)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            ph         <= '0;
            sc         <= '0;
            sam_clk_en <= 1'b0;
            sym_clk_en <= 1'b0;
            x_out      <= '0;
            sym_out    <= 2'b00;
        end else begin
            ph <= ph + PH_W'(1);
            if (ph == PH_LAST) begin
                sc <= sc + SC_W'(1);
            end
            // Strobes are registered one phase early so they are high while ph==3.
            sam_clk_en <= (ph == PH_PRE);
            sym_clk_en <= (ph == PH_PRE) && (sc == SC_LAST);
            if (sym_load) begin
                if (run) begin
                    x_out   <= lvl;
                    sym_out <= bits;
                end else begin
                    x_out   <= '0;
                    sym_out <= 2'b00;
                end
            end
`ifndef GSM_SRC_ZOH_EN
            else if (load_edge) begin
                x_out <= '0;
            end
`endif
        end
    end

endmodule

// File: doc/gsm_sym_source.md
# gsm_sym_source

Test-signal source and timing master that sits directly upstream of the time-shared GSM pulse-shaping filter. It generates the sample-rate clock enable (1 in 4 `sys_clk`) and symbol-rate enable (1 in 4 samples), draws 2-bit symbols from a PRBS-22 generator, maps them to 4-ASK levels in 1s17, and upsamples ×4 into the filter's `x_in`.

## Interface
Parameters:
- `WIDTH`, 18, sample word width (1s17).
- `MAG`, 18'sd32768, inner level `a` (0.25 in 1s17); outer level is `3*MAG`.
- `SEED`, 22'h3FFFFF, LFSR reset value; all-zero is illegal and is replaced by 22'h000001.

Ports:
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `run`  in  1  1 = emit PRBS symbols; 0 = emit zeros with the LFSR frozen.
- `sam_clk_en`  out  1  one-cycle sample strobe, every 4 `sys_clk`.
- `sym_clk_en`  out  1  one-cycle symbol strobe, every 16 `sys_clk`, coincident with the last `sam_clk_en` of a symbol.
- `x_out`  out  WIDTH  signed 1s17 upsampled sample, driven to the filter's `x_in`.
- `sym_out`  out  2  Gray bits of the current symbol, for the checker.

## Operation
- Phase counter `ph` (2 bit) wraps 0→3 every cycle. Sample counter `sc` (2 bit) increments on the edge leaving `ph==3`.
- LFSR: 22-bit Fibonacci, x^22+x^21+1. Shift left with `new = lfsr[21]^lfsr[20]`. Advances 2 steps per symbol, only when `run` is 1.
- Symbol bits are `{lfsr[21],lfsr[20]}`, taken before the advance. Gray map: 00→−3a, 01→−a, 11→+a, 10→+3a. The arithmetic is an exact constant select with no rounding; ±3a must fit in WIDTH.
- Load edge is the edge leaving `ph==1`.
  - When `sc==0`, the load edge is a symbol load: `run` is sampled; `x_out`=map(bits) and `sym_out`=bits if `run` is 1, else `x_out`=0 and `sym_out`=00.
  - When `sc!=0`, the load edge writes `x_out`=0 (zero stuffing).
- Changing `run` mid-symbol has no effect until the next symbol load.
- Strobes keep running regardless of `run`.

## Timing
- Reset values: `ph`=0, `sc`=0, `lfsr`=SEED, and all outputs (`sam_clk_en`, `sym_clk_en`, `x_out`, `sym_out`) are 0. Reset is asynchronous assert with synchronous release by edge count. Reset mid-symbol aborts the symbol immediately.
- All outputs are registered. Edges are counted from the first rising edge after `reset_n` rises.
  - `sam_clk_en` is high during each cycle with `ph==3`, first in cycle 4. Period 4.
  - `sym_clk_en` is high when `ph==3 && sc==3`, first in cycle 16. Period 16.
  - The first symbol appears on `x_out` at edge 2 (`ph` 1→2) and stays stable through the following `sam_clk_en` cycle. The filter captures it at edge 4.
- `x_out` only changes at load edges, so it is stable for 2 cycles before each `sam_clk_en` capture edge.
- Latency from LFSR state to `x_out` is 1 edge.

## Configuration
- `GSM_SRC_ZOH_EN`:
  - Defined: zero-order hold. The 2nd–4th samples of a symbol repeat the symbol value; the `sc!=0` load edges leave `x_out` unchanged.
  - Undefined: zero stuffing as above. This is the default for the filter gain budget.

## Structure
- Package `gsm_src_pkg`:
  - Level constants `LVL_N3`, `LVL_N1`, `LVL_P1`, `LVL_P3` derived from `MAG`.
  - LFSR width 22 and tap positions 21/20.
  - Upsample factor 4 and samples-per-symbol 4.
  - Gray-map function.
- Sub-module `gsm_lfsr22`: seedable PRBS-22 with an advance-by-2 enable and a 2-bit tap output.
- The counters, mapper and output registers live in the top.

## Test plan
- Reset release, `run`=1, default SEED → `sam_clk_en` high in cycles 4, 8, 12…; `sym_clk_en` high in cycles 16, 32…; never high when `ph!=3`.
- SEED=all ones, ZOH off:
  - symbols 1–11 give `x_out`=+32768 then 0, 0, 0;
  - symbols 12–13 give −98304;
  - `sym_out` is 11, 11, …, 00, 00.
- Same stimulus with `GSM_SRC_ZOH_EN` → each of the 4 samples of a symbol equals the symbol value, e.g. 4×+32768.
- `run` dropped at cycle 20 (mid-symbol 2):
  - symbol 2 completes unchanged;
  - from symbol 3, `x_out`=0 and `sym_out`=00;
  - raising `run` resumes with symbol 3 = the value the LFSR would have produced, i.e. no bits are skipped.
- `reset_n` pulsed low at cycle 37 → all outputs 0 immediately (asynchronous); after release, the sequence repeats exactly from symbol 1.
- SEED=0 → behaves as seed 1: symbols start 00 (−98304). Across 2^22−1 symbols the LFSR period check passes.
